// File: rtl/seg_display_pkg.sv
// rtl/seg_display_pkg.sv - shared glyph table, segment bit positions and index widths for the scanned display
package seg_display_pkg;

   localparam int IDX_W    = 4;
   localparam int BRIGHT_W = 4;

   localparam int SEG_A  = 0;
   localparam int SEG_G  = 6;
   localparam int SEG_DP = 7;

   // Active-high glyphs, bit SEG_A..SEG_G = a..g; b and d are lower-case forms
   function automatic logic [6:0] hex_glyph(input logic [3:0] nibble);
      logic [6:0] g;
      g = 7'h00;
      case (nibble)
         4'h0: g = 7'h3F;
         4'h1: g = 7'h06;
         4'h2: g = 7'h5B;
         4'h3: g = 7'h4F;
         4'h4: g = 7'h66;
         4'h5: g = 7'h6D;
         4'h6: g = 7'h7D;
         4'h7: g = 7'h07;
         4'h8: g = 7'h7F;
         4'h9: g = 7'h6F;
         4'hA: g = 7'h77;
         4'hB: g = 7'h7C;
         4'hC: g = 7'h39;
         4'hD: g = 7'h5E;
         4'hE: g = 7'h79;
         4'hF: g = 7'h71;
         default: g = 7'h00;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/refresh_timer.sv
// rtl/refresh_timer.sv - free-running prescaler that steps the scanned digit index and flags frame wraps
module refresh_timer
   import seg_display_pkg::*;
#(
   parameter int NUM_DIGITS    = 8,
   parameter int PRESCALE_BITS = 12
) (
   input  logic                clock,
   input  logic                reset,
   output logic [IDX_W-1:0]    idx,
   output logic [BRIGHT_W-1:0] phase,
   output logic                frame_wrap
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

   logic [PRESCALE_BITS-1:0] prescaler;
   logic                     terminal;
   logic                     last_idx;

   assign terminal   = &prescaler;
   assign last_idx   = (idx == LAST_IDX);
   assign frame_wrap = terminal & last_idx;
   assign phase      = prescaler[PRESCALE_BITS-1 -: BRIGHT_W];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         prescaler <= '0;
         idx       <= '0;
      end else begin
         prescaler <= prescaler + PRESCALE_BITS'(1);
         if (terminal) begin
            idx <= last_idx ? '0 : idx + IDX_W'(1);
         end
      end
   end

endmodule

// File: rtl/multi_digit_display.sv
// rtl/multi_digit_display.sv - multiplexed hex display driver with PWM dimming and leading-zero blanking
// Optional MULTI_DIGIT_DISPLAY_BLINK_EN adds blink_mask and a 32-frame blink cycle.
module multi_digit_display
   import seg_display_pkg::*;
#(
   parameter int NUM_DIGITS    = 8,
   parameter int PRESCALE_BITS = 12,
   parameter int ACTIVE_LOW    = 1
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic [NUM_DIGITS-1:0]   dots,
   input  logic                    load,
   input  logic [BRIGHT_W-1:0]     brightness,
   input  logic                    blank_lz,
`ifdef MULTI_DIGIT_DISPLAY_BLINK_EN
   input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
   output logic [7:0]              segment,
   output logic [NUM_DIGITS-1:0]   digit,
   output logic                    frame_done
);

   // XOR masks that turn active-high internal levels into the pin polarity
   localparam logic [7:0]            SEG_OFF = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
   localparam logic [NUM_DIGITS-1:0] DIG_OFF = (ACTIVE_LOW != 0) ? '1 : '0;

   logic [IDX_W-1:0]        idx;
   logic [BRIGHT_W-1:0]     phase;
   logic                    frame_wrap;

   logic [4*NUM_DIGITS-1:0] shadow_value, active_value;
   logic [NUM_DIGITS-1:0]   shadow_dots, active_dots;
   logic                    wrap_d;

   logic [3:0]              cur_nibble;
   logic                    cur_dot;
   logic [NUM_DIGITS-1:0]   cur_onehot;
   logic                    seen;
   logic                    blanked;
   logic                    blink_off;
   logic                    lit;
   logic [7:0]              seg_on;
   logic [7:0]              seg_next;
   logic [NUM_DIGITS-1:0]   dig_next;

   refresh_timer #(
      .NUM_DIGITS   (NUM_DIGITS),
      .PRESCALE_BITS(PRESCALE_BITS)
   ) u_timer (
      .clock     (clock),
      .reset     (reset),
      .idx       (idx),
      .phase     (phase),
      .frame_wrap(frame_wrap)
   );

   // Active data only changes on the wrap so a frame never mixes old and new digits
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         shadow_value <= '0;
         shadow_dots  <= '0;
         active_value <= '0;
         active_dots  <= '0;
         wrap_d       <= 1'b0;
      end else begin
         if (load) begin
            shadow_value <= value;
            shadow_dots  <= dots;
         end
         if (frame_wrap) begin
            active_value <= load ? value : shadow_value;
            active_dots  <= load ? dots  : shadow_dots;
         end
         wrap_d <= frame_wrap;
      end
   end

`ifdef MULTI_DIGIT_DISPLAY_BLINK_EN
   logic [4:0] blink_cnt;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         blink_cnt <= '0;
      end else if (frame_wrap) begin
         blink_cnt <= blink_cnt + 5'd1;
      end
   end

   assign blink_off = blink_cnt[4] & (|(blink_mask & cur_onehot));
`else
   assign blink_off = 1'b0;
`endif

   // Scan from the top digit down so "seen" marks any content at or above digit k
   always_comb begin
      cur_nibble = 4'h0;
      cur_dot    = 1'b0;
      cur_onehot = '0;
      seen       = 1'b0;
      blanked    = 1'b0;
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
         seen = seen | (active_value[4*k +: 4] != 4'h0) | active_dots[k];
         if (idx == IDX_W'(k)) begin
            cur_nibble    = active_value[4*k +: 4];
            cur_dot       = active_dots[k];
            cur_onehot[k] = 1'b1;
            blanked       = blank_lz & ~seen & (k != 0);
         end
      end
   end

   always_comb begin
      seg_on              = 8'h00;
      seg_on[SEG_DP]      = cur_dot;
      seg_on[SEG_G:SEG_A] = hex_glyph(cur_nibble);
      lit                 = ~blanked & ~blink_off & (phase < brightness);
      seg_next            = lit ? seg_on : 8'h00;
      dig_next            = lit ? cur_onehot : '0;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         segment    <= SEG_OFF;
         digit      <= DIG_OFF;
         frame_done <= 1'b0;
      end else begin
         segment    <= seg_next ^ SEG_OFF;
         digit      <= dig_next ^ DIG_OFF;
         frame_done <= wrap_d;
      end
   end

endmodule

// File: tb/tb_multi_digit_display.sv
// tb/tb_multi_digit_display.sv - randomized scoreboard bench for multi_digit_display against a cycle-count reference model
module tb_multi_digit_display;

   localparam int N     = 4;
   localparam int PB    = 6;
   localparam int SLOT  = 1 << PB;
   localparam int FRAME = SLOT * N;

   localparam logic [6:0] GLYPH [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                         7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   typedef struct packed {
      int         t;
      logic [7:0] seg;
      logic [3:0] dig;
      logic       fd;
   } exp_t;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] value = '0;
   logic [3:0]  dots = '0;
   logic        load = 1'b0;
   logic [3:0]  brightness = 4'd15;
   logic        blank_lz = 1'b0;
   logic [3:0]  blink_mask = 4'h0;
   logic [7:0]  segment;
   logic [3:0]  digit;
   logic        frame_done;

   exp_t        sb[$];
   exp_t        got_e;
   int          tests = 0;
   int          fails = 0;
   int          popped = 0;
   int          edge_cnt = 0;
   logic [15:0] m_sh_v = '0, m_act_v = '0;
   logic [3:0]  m_sh_d = '0, m_act_d = '0;

   always #5 clock = ~clock;

   multi_digit_display #(
      .NUM_DIGITS   (N),
      .PRESCALE_BITS(PB),
      .ACTIVE_LOW   (1)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .value     (value),
      .dots      (dots),
      .load      (load),
      .brightness(brightness),
      .blank_lz  (blank_lz),
`ifdef MULTI_DIGIT_DISPLAY_BLINK_EN
      .blink_mask(blink_mask),
`endif
      .segment   (segment),
      .digit     (digit),
      .frame_done(frame_done)
   );

   // Expected pins after edge t, from elapsed time and the displayed data
   function automatic exp_t model_out(int t, logic [15:0] av, logic [3:0] ad, logic [3:0] br,
                                      logic blz, logic [3:0] bm);
      int   idx   = (t / SLOT) % N;
      int   ph    = (t % SLOT) / 4;
      int   frame = t / FRAME;
      int   top   = -1;
      logic off;
      exp_t e;
      for (int k = 0; k < N; k++)
         if (av[4*k +: 4] != 4'h0 || ad[k]) top = k;
      off = (ph >= int'(br)) || (blz && idx > top && idx != 0) || (bm[idx] && (frame % 32) >= 16);
      e.t  = t;
      e.fd = (t > 0) && (t % FRAME == 0);
      if (off) begin
         e.seg = 8'hFF;
         e.dig = 4'hF;
      end else begin
         e.seg = ~{ad[idx], GLYPH[av[4*idx +: 4]]};
         e.dig = ~(4'b0001 << idx);
      end
      return e;
   endfunction

   always @(posedge clock) begin
      if (reset) begin
         edge_cnt <= 0;
         m_sh_v <= '0;  m_sh_d <= '0;
         m_act_v <= '0; m_act_d <= '0;
      end else begin
         sb.push_back(model_out(edge_cnt, m_act_v, m_act_d, brightness, blank_lz, blink_mask));
         if (load) begin
            m_sh_v <= value;
            m_sh_d <= dots;
         end
         if (edge_cnt % FRAME == FRAME - 1) begin
            m_act_v <= load ? value : m_sh_v;
            m_act_d <= load ? dots  : m_sh_d;
         end
         edge_cnt <= edge_cnt + 1;
      end
   end

   always @(negedge clock) begin
      if (!reset && sb.size() > 0) begin
         got_e = sb.pop_front();
         popped++;
         tests++;
         if (segment !== got_e.seg || digit !== got_e.dig || frame_done !== got_e.fd) begin
            fails++;
            if (fails <= 20)
               $display("FAIL scoreboard t=%0d: got seg=%h dig=%h fd=%b, expected seg=%h dig=%h fd=%b",
                        got_e.t, segment, digit, frame_done, got_e.seg, got_e.dig, got_e.fd);
         end
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, got, want);
      end
   endtask

   task automatic run(input int n);
      repeat (n) @(posedge clock);
   endtask

   task automatic load_now(input logic [15:0] v, input logic [3:0] d);
      value = v;
      dots  = d;
      load  = 1'b1;
      @(posedge clock); #1;
      load  = 1'b0;
   endtask

   task automatic pulse_load(input logic [15:0] v, input logic [3:0] d);
      @(posedge clock); #1;
      load_now(v, d);
   endtask

   // Leaves the bench just after an edge such that the next edge has index target (mod FRAME)
   task automatic wait_phase(input int target);
      int guard = 0;
      do begin
         @(posedge clock); #1;
         guard++;
      end while ((edge_cnt % FRAME) != target && guard < 2 * FRAME);
      check("wait_phase_bound", guard < 2 * FRAME, 1);
   endtask

   task automatic do_reset(input logic with_load);
      @(negedge clock); #1;
      if (with_load) begin
         value = 16'hBEEF;
         dots  = 4'hF;
         load  = 1'b1;
      end
      reset = 1'b1;
      #1;
      check("reset_segment", segment, 8'hFF);
      check("reset_digit", digit, 4'hF);
      check("reset_frame_done", frame_done, 1'b0);
      load = 1'b0;
      sb.delete();
      run(2);
      @(negedge clock); #1;
      reset = 1'b0;
   endtask

   initial begin
      logic [15:0] v;
      logic [3:0]  d;

      do_reset(1'b0);

      pulse_load(16'h1234, 4'h0);
      run(2 * FRAME);

      blank_lz = 1'b1;
      pulse_load(16'h00A5, 4'h0);
      run(2 * FRAME);
      pulse_load(16'h00A5, 4'b1000);
      run(2 * FRAME);

      brightness = 4'd4;
      run(FRAME);
      brightness = 4'd0;
      run(FRAME);
      brightness = 4'd15;
      blank_lz = 1'b0;

      wait_phase(100);
      load_now(16'hFFFF, 4'h0);
      run(300);
      wait_phase(FRAME - 1);
      load_now(16'h5A5A, 4'h3);
      run(300);

      wait_phase(FRAME + 37 - FRAME);
      do_reset(1'b1);
      run(2 * FRAME + 10);

      for (int i = 0; i < 30; i++) begin
         for (int k = 0; k < 4; k++)
            v[4*k +: 4] = ($urandom % 2 == 1) ? 4'($urandom % 16) : 4'h0;
         d = ($urandom % 3 == 0) ? 4'($urandom & $urandom) : 4'h0;
         @(posedge clock); #1;
         brightness = 4'($urandom % 16);
         blank_lz   = 1'($urandom % 2);
         if ($urandom % 4 == 0) begin
            wait_phase(FRAME - 1);
            load_now(v, d);
         end else begin
            pulse_load(v, d);
         end
         run($urandom_range(1, 400));
      end

`ifdef MULTI_DIGIT_DISPLAY_BLINK_EN
      do_reset(1'b0);
      brightness = 4'd15;
      blank_lz   = 1'b0;
      blink_mask = 4'b0001;
      pulse_load(16'h1234, 4'h0);
      run(48 * FRAME);
`endif

      run(2);
      @(negedge clock); #1;
      check("scoreboard_drained", sb.size(), 0);
      check("scoreboard_activity", popped >= 1000, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/multi_digit_display.md
MULTI_DIGIT_DISPLAY -- requirements
Module: multi_digit_display

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 8, number of multiplexed hex digits (legal 2..16).
REQ-002 SHALL have parameter PRESCALE_BITS, default 12, refresh prescaler width (legal 6..24).
REQ-003 SHALL have parameter ACTIVE_LOW, default 1; 1 means segment and digit outputs are driven low-true.
REQ-004 SHALL have port clock, input, 1, sole clock; all logic is on the rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port value, input, 4*NUM_DIGITS, hex nibbles; nibble k drives digit k, and digit 0 is rightmost.
REQ-007 SHALL have port dots, input, NUM_DIGITS, decimal-point request per digit.
REQ-008 SHALL have port load, input, 1, single-cycle strobe that captures value and dots.
REQ-009 SHALL have port brightness, input, 4, PWM duty level; 0 is dark.
REQ-010 SHALL have port blank_lz, input, 1, leading-zero blanking enable.
REQ-011 SHALL have port segment, output, 8; bit 7 is dp, bits 6:0 are g..a.
REQ-012 SHALL have port digit, output, NUM_DIGITS, one-hot digit enable.
REQ-013 SHALL have port frame_done, output, 1, one-cycle pulse per completed scan frame.

Function
REQ-014 SHALL include a free-running PRESCALE_BITS counter; the terminal count (all ones) advances the digit index idx.
- idx counts 0..NUM_DIGITS-1, then wraps to 0.
REQ-015 SHALL capture value/dots into shadow registers on any clock where load=1.
REQ-016 SHALL copy shadow to the active registers only at frame boundaries (the idx NUM_DIGITS-1→0 advance), so no frame tears.
REQ-017 SHALL, if load coincides with a frame boundary, transfer the newly presented value/dots directly to the active registers that cycle.
REQ-018 SHALL define PWM phase as prescaler[PRESCALE_BITS-1 -: 4].
- Selected digit is enabled only while phase < brightness.
- brightness=0 → fully dark; brightness=15 → 15/16 duty.
REQ-019 SHALL apply leading-zero blanking when blank_lz=1.
- Blank digit k if its active nibble and all higher nibbles are 0 and its dot and all higher dots are clear.
- Digit 0 is never blanked.
REQ-020 SHALL drive a blanked or PWM-off slot as all digit lines inactive and all segments off.
REQ-021 SHALL register segment and digit; they reflect a new idx exactly one clock after the idx change.
REQ-022 SHALL pulse frame_done for one clock, aligned with the registered output of the idx wrap to 0.
REQ-023 SHALL honour ACTIVE_LOW: 1 means 0=lit/enabled; 0 means 1=lit/enabled.
REQ-024 SHALL decode hex 0-F using the standard 7-segment glyphs, with lower-case b and d.

Reset
REQ-025 SHALL, while reset is asserted, clear the prescaler, idx, shadow and active registers, and blink counter.
- Forces digit and segment to inactive/off per ACTIVE_LOW, and frame_done=0.
REQ-026 SHALL, when reset is asserted mid-frame, abandon the frame immediately; scanning restarts at idx 0 with no frame_done pulse.
REQ-027 SHALL cause a load pending at reset assertion to be lost.

Configuration
REQ-028 SHALL support macro MULTI_DIGIT_DISPLAY_BLINK_EN.
- Defined: adds input blink_mask [NUM_DIGITS-1:0] and a 5-bit frame counter; masked digits are blanked while counter bit 4 is 1 (16 frames off, 16 on).
- Undefined: no port, no counter, no blinking.

Structure
REQ-029 SHALL place the hex-to-segment glyph table, segment bit-position constants, and the idx/brightness widths in package seg_display_pkg.
REQ-030 SHALL implement the prescaler plus idx as sub-module refresh_timer, which outputs idx, phase and frame_wrap.

Verification
REQ-031 Reset release, NUM_DIGITS=4, PRESCALE_BITS=6, ACTIVE_LOW=1, value=16'h1234, load pulse, brightness=15 → digit cycles 1110,1101,1011,0111 with segments for 4,3,2,1.
REQ-032 Load 16'h00A5, blank_lz=1 → digits 3,2 dark, digit 1 shows A, digit 0 shows 5; with dots=4'b1000, all four digits are lit.
REQ-033 brightness=4 → each digit lit exactly 4 of 16 phase steps; brightness=0 → digit stays all ones for a full frame.
REQ-034 Load 16'hFFFF mid-frame → displayed data unchanged until next frame_done; load asserted on the wrap cycle → new data appears in that same frame.
REQ-035 Reset asserted mid-frame → outputs inactive asynchronously; after release, first digit is idx 0 and frame_done does not pulse until a full frame elapses.
REQ-036 With MULTI_DIGIT_DISPLAY_BLINK_EN, blink_mask=4'b0001 → digit 0 dark in frames 16-31 and lit in frames 0-15 and 32-47.
